// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with 2-entry skid-buffered EX/MEM output
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [RD_W-1:0]  out_rd
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam int         MSB    = WIDTH - 1;
  // Beat layout: {result, zero, ovf, illegal, rd}
  localparam int         BW     = WIDTH + 3 + RD_W;

  logic [WIDTH-1:0] c_result;
  logic             c_zero;
  logic             c_ovf;
  logic             c_illegal;
  logic [BW-1:0]    c_beat;

  logic [BW-1:0]    main_q, main_d;
  logic [BW-1:0]    skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;

  logic             accept;
  logic             drain;

  // ALU evaluated on the input side so only finished fields are stored
  always_comb begin
    c_result  = '0;
    c_ovf     = 1'b0;
    c_illegal = 1'b0;
    case (in_ctrl)
      OP_ADD: begin
        c_result = in_a + in_b;
        c_ovf    = (in_a[MSB] == in_b[MSB]) && (c_result[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        c_result = in_a - in_b;
        c_ovf    = (in_a[MSB] != in_b[MSB]) && (c_result[MSB] != in_a[MSB]);
      end
      OP_AND:  c_result = in_a & in_b;
      OP_OR:   c_result = in_a | in_b;
      default: c_illegal = 1'b1;
    endcase
    c_zero = (c_result == '0);
    c_beat = {c_result, c_zero, c_ovf, c_illegal, in_rd};
  end

  // Ready comes straight from a flop so back-pressure never forms a combinational path
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = main_valid_q && out_ready;

  // Next-state selection for main/skid, flush first, then promotion, then fills
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || drain)) begin
      main_d       = c_beat;
      main_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = c_beat;
      skid_valid_d = 1'b1;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; reset clears both valid flags and zeroes the output fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign {out_result, out_zero, out_ovf, out_illegal, out_rd} = main_q;

endmodule
